// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- parametrised UART receiver with 16x oversampling.
//
// The serial line is resynchronised by two flip-flops. A falling edge
// (previous sample 1, current sample 0) starts a frame. The start bit is
// re-checked half a bit later. Data bits (LSB first), the optional parity
// bit and the stop bit are then sampled in the middle of each bit.
// A frame that ends with an all-zero word, a zero parity bit and a zero stop
// bit is reported as a line break. The receiver then waits for the line to
// return high before it looks for the next start edge.
//
// Parameters
//   DBIT     data bits per frame (5..9)
//   SB_TICK  stop length in ticks (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//   PARITY   0 = none, 1 = even, 2 = odd
//
// Ports
//   i_clk           system clock
//   i_reset         synchronous active-high reset
//   i_s_tick        1-clk oversample tick at 16x baud
//   i_rx            asynchronous serial input, idle high
//   o_rx_done_tick  1-clk pulse when a frame completes
//   o_dout          received word, held until the next done
//   o_parity_err    parity mismatch on the last frame
//   o_frame_err     stop bit sampled low on the last frame
//   o_break         last frame was a line break
//   o_busy          receiver is not idle
module uart_rx_cfg #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_s_tick,
   input  logic            i_rx,
   output logic            o_rx_done_tick,
   output logic [DBIT-1:0] o_dout,
   output logic            o_parity_err,
   output logic            o_frame_err,
   output logic            o_break,
   output logic            o_busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } state_t;

   localparam logic [4:0] S_MID       = 5'd7;
   localparam logic [4:0] S_LAST      = 5'd15;
   localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [3:0] N_LAST      = 4'(DBIT - 1);

   // Parity error for the captured word plus the received parity bit.
   function automatic logic parity_error(input logic [DBIT-1:0] data, input logic pbit);
      logic err;
      case (PARITY)
         1:       err = ^{data, pbit};
         2:       err = ~^{data, pbit};
         default: err = 1'b0;
      endcase
      return err;
   endfunction

   // Line break: every sampled bit of the frame was low.
   function automatic logic is_break(input logic [DBIT-1:0] data, input logic pbit,
                                     input logic stop);
      logic par_low;
      if (PARITY != 0) begin
         par_low = ~pbit;
      end else begin
         par_low = 1'b1;
      end
      return (data == '0) && par_low && !stop;
   endfunction

   // Synchroniser, edge detector and arming state
   logic       sync1_q, rx_s_q, rx_q;
   logic [1:0] vld_q;   // vld_q[1]: rx_s_q holds a real line sample
   logic       arm_q;   // line has been seen high since reset
   logic       fall_s;

   // Receiver state
   state_t          state_q, state_d;
   logic [4:0]      s_q, s_d;
   logic [3:0]      n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            pbit_q, pbit_d;
   logic            pcalc_q, pcalc_d;
   logic            stop_q, stop_d;
   logic            stop_now_s;

   // Output registers
   logic            done_q, done_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic            brk_q, brk_d;
   logic            busy_q;

   // Two-FF synchroniser, previous-sample register and start arming.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         rx_q    <= 1'b1;
         vld_q   <= 2'b00;
         arm_q   <= 1'b0;
      end else begin
         sync1_q <= i_rx;
         rx_s_q  <= sync1_q;
         rx_q    <= rx_s_q;
         vld_q   <= {vld_q[0], 1'b1};
         // The preset synchroniser value is not a real sample, so a line
         // held low through reset must first be seen high before it arms.
         arm_q   <= arm_q | (vld_q[1] & rx_s_q);
      end
   end

   assign fall_s = arm_q & rx_q & ~rx_s_q;

   // With a 1-stop frame the stop sample and the finish share one tick.
   assign stop_now_s = (s_q == S_LAST) ? rx_s_q : stop_q;

   // Next-state and output-load logic of the receive FSM.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      pbit_d  = pbit_q;
      pcalc_d = pcalc_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      dout_d  = dout_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      brk_d   = brk_q;

      case (state_q)
         ST_IDLE: begin
            // A tick in the same clk as the edge is not counted.
            if (fall_s) begin
               state_d = ST_START;
               s_d     = 5'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (i_s_tick) begin
               if (s_q == S_MID) begin
                  if (!rx_s_q) begin
                     state_d = ST_DATA;
                     s_d     = 5'd0;
                     n_d     = 4'd0;
                  end else begin
                     state_d = ST_IDLE;   // glitch, not a start bit
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end else begin
               s_d = s_q;
            end
         end
         ST_DATA: begin
            if (i_s_tick) begin
               if (s_q == S_LAST) begin
                  b_d = {rx_s_q, b_q[DBIT-1:1]};
                  s_d = 5'd0;
                  if (n_q == N_LAST) begin
                     if (PARITY != 0) begin
                        state_d = ST_PARITY;
                     end else begin
                        state_d = ST_STOP;
                     end
                  end else begin
                     n_d = n_q + 4'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end else begin
               s_d = s_q;
            end
         end
         ST_PARITY: begin
            if (i_s_tick) begin
               if (s_q == S_LAST) begin
                  pbit_d  = rx_s_q;
                  pcalc_d = parity_error(b_q, rx_s_q);
                  s_d     = 5'd0;
                  state_d = ST_STOP;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end else begin
               s_d = s_q;
            end
         end
         ST_STOP: begin
            if (i_s_tick) begin
               if (s_q == S_LAST) begin
                  stop_d = rx_s_q;
               end else begin
                  stop_d = stop_q;
               end
               if (s_q == S_STOP_LAST) begin
                  done_d = 1'b1;
                  dout_d = b_q;
                  perr_d = (PARITY != 0) ? pcalc_q : 1'b0;
                  ferr_d = ~stop_now_s;
                  brk_d  = is_break(b_q, pbit_q, stop_now_s);
                  s_d    = 5'd0;
                  if (is_break(b_q, pbit_q, stop_now_s)) begin
                     state_d = ST_BRK;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end else begin
               s_d = s_q;
            end
         end
         ST_BRK: begin
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BRK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, counters, shift register and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         s_q     <= 5'd0;
         n_q     <= 4'd0;
         b_q     <= '0;
         pbit_q  <= 1'b0;
         pcalc_q <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         pbit_q  <= pbit_d;
         pcalc_q <= pcalc_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         brk_q   <= brk_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign o_rx_done_tick = done_q;
   assign o_dout         = dout_q;
   assign o_parity_err   = perr_q;
   assign o_frame_err    = ferr_q;
   assign o_break        = brk_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg. Four receivers with different configurations
// share one clock, tick and reset; each has its own serial line. Expected
// frame results come from a frame-level model and are queued per receiver,
// then matched against each done pulse.
module tb_uart_rx_cfg;

   localparam int TICK_DIV = 4;   // clk per oversample tick

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   int         tdiv = 0;
   int         tick_total = 0;
   logic [3:0] rx = 4'hF;

   logic [3:0] done, perr, ferr, brk, busy;
   logic [7:0] dout0, dout1, dout2;
   logic [4:0] dout3;

   int n_cmp = 0;
   int n_bad = 0;
   int start3 = 0;

   logic [11:0] q0[$];
   logic [11:0] q1[$];
   logic [11:0] q2[$];
   logic [11:0] q3[$];

   always #10 clk = ~clk;

   // Tick generator and running tick count.
   always @(posedge clk) begin
      if (tdiv == TICK_DIV - 1) begin
         tdiv <= 0;
         tick <= 1'b1;
      end else begin
         tdiv <= tdiv + 1;
         tick <= 1'b0;
      end
      if (tick) tick_total <= tick_total + 1;
   end

   uart_rx_cfg #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
      .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx[0]),
      .o_rx_done_tick(done[0]), .o_dout(dout0), .o_parity_err(perr[0]),
      .o_frame_err(ferr[0]), .o_break(brk[0]), .o_busy(busy[0]));
   uart_rx_cfg #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
      .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx[1]),
      .o_rx_done_tick(done[1]), .o_dout(dout1), .o_parity_err(perr[1]),
      .o_frame_err(ferr[1]), .o_break(brk[1]), .o_busy(busy[1]));
   uart_rx_cfg #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
      .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx[2]),
      .o_rx_done_tick(done[2]), .o_dout(dout2), .o_parity_err(perr[2]),
      .o_frame_err(ferr[2]), .o_break(brk[2]), .o_busy(busy[2]));
   uart_rx_cfg #(.DBIT(5), .SB_TICK(32), .PARITY(0)) u3 (
      .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx[3]),
      .o_rx_done_tick(done[3]), .o_dout(dout3), .o_parity_err(perr[3]),
      .o_frame_err(ferr[3]), .o_break(brk[3]), .o_busy(busy[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int cfg_bits(int idx);
      return (idx == 3) ? 5 : 8;
   endfunction
   function automatic int cfg_par(int idx);
      return (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
   endfunction
   function automatic int cfg_stop(int idx);
      return (idx == 3) ? 32 : 16;
   endfunction

   // Frame-level result: {break, frame_err, parity_err, word[8:0]}.
   function automatic logic [11:0] model(int pmode, int nbits, logic [8:0] data,
                                         logic pbit, logic stop);
      int         ones;
      logic [8:0] d;
      logic       pe, br;
      ones = 0;
      d = 9'h000;
      for (int i = 0; i < nbits; i++) begin
         d[i] = data[i];
         if (data[i]) ones++;
      end
      if (pmode == 1)      pe = ((ones + int'(pbit)) % 2) == 1;
      else if (pmode == 2) pe = ((ones + int'(pbit)) % 2) == 0;
      else                 pe = 1'b0;
      br = (ones == 0) && (pmode == 0 || !pbit) && !stop;
      return {br, !stop, pe, d};
   endfunction

   task automatic push_exp(int idx, logic [11:0] e);
      case (idx)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   task automatic on_done(int idx, logic [11:0] obs);
      logic [11:0] e;
      int sz;
      case (idx)
         0: sz = q0.size();
         1: sz = q1.size();
         2: sz = q2.size();
         default: sz = q3.size();
      endcase
      chk($sformatf("u%0d_done_expected", idx), 32'(sz != 0), 32'd1);
      if (sz != 0) begin
         case (idx)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
         endcase
         chk($sformatf("u%0d_dout", idx), 32'(obs[8:0]), 32'(e[8:0]));
         chk($sformatf("u%0d_parity_err", idx), 32'(obs[9]), 32'(e[9]));
         chk($sformatf("u%0d_frame_err", idx), 32'(obs[10]), 32'(e[10]));
         chk($sformatf("u%0d_break", idx), 32'(obs[11]), 32'(e[11]));
      end
   endtask

   // Done-pulse monitors, sampled away from the active edge.
   always @(negedge clk) begin
      if (done[0]) on_done(0, {brk[0], ferr[0], perr[0], 1'b0, dout0});
      if (done[1]) on_done(1, {brk[1], ferr[1], perr[1], 1'b0, dout1});
      if (done[2]) on_done(2, {brk[2], ferr[2], perr[2], 1'b0, dout2});
      if (done[3]) begin
         on_done(3, {brk[3], ferr[3], perr[3], 4'b0, dout3});
         chk("u3_latency_ticks", 32'(tick_total - start3), 32'd120);
      end
   end

   task automatic wait_ticks(int n);
      repeat (n) @(posedge clk iff tick);
      #1;
   endtask

   // Drive one frame onto line idx, bit edges aligned just after a tick.
   task automatic send(int idx, logic [8:0] data, logic pbit, logic stop_val);
      wait_ticks(1);
      if (idx == 3) start3 = tick_total;
      rx[idx] = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < cfg_bits(idx); i++) begin
         rx[idx] = data[i];
         wait_ticks(16);
      end
      if (cfg_par(idx) != 0) begin
         rx[idx] = pbit;
         wait_ticks(16);
      end
      rx[idx] = stop_val;
      wait_ticks(cfg_stop(idx));
      rx[idx] = 1'b1;
      wait_ticks(4);
   endtask

   task automatic frame(int idx, logic [8:0] data, logic pbit, logic stop_val);
      push_exp(idx, model(cfg_par(idx), cfg_bits(idx), data, pbit, stop_val));
      send(idx, data, pbit, stop_val);
   endtask

   initial begin
      logic [8:0] d;
      logic       pb;
      logic       sv;
      int         idx;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      chk("u0_reset_outputs", {done[0], brk[0], ferr[0], perr[0], busy[0], 19'd0, dout0}, 32'd0);
      chk("u1_reset_outputs", {done[1], brk[1], ferr[1], perr[1], busy[1], 19'd0, dout1}, 32'd0);
      chk("u2_reset_outputs", {done[2], brk[2], ferr[2], perr[2], busy[2], 19'd0, dout2}, 32'd0);
      chk("u3_reset_outputs", {done[3], brk[3], ferr[3], perr[3], busy[3], 22'd0, dout3}, 32'd0);
      rst = 1'b0;
      wait_ticks(4);

      // 8N1 word
      frame(0, 9'h0A5, 1'b0, 1'b1);
      chk("t1_busy_after", 32'(busy[0]), 32'd0);

      // Parity: even good, even bad, odd bad
      frame(1, 9'h055, 1'b0, 1'b1);
      frame(1, 9'h055, 1'b1, 1'b1);
      frame(2, 9'h055, 1'b0, 1'b1);

      // Stop bit low
      frame(0, 9'h03C, 1'b0, 1'b0);

      // Start glitch of 4 ticks
      wait_ticks(1);
      rx[0] = 1'b0;
      wait_ticks(2);
      chk("t4_busy_in_glitch", 32'(busy[0]), 32'd1);
      wait_ticks(2);
      rx[0] = 1'b1;
      wait_ticks(4);
      chk("t4_busy_after_glitch", 32'(busy[0]), 32'd0);
      frame(0, 9'h081, 1'b0, 1'b1);

      // Line break of two frame times
      push_exp(0, model(0, 8, 9'h000, 1'b0, 1'b0));
      wait_ticks(1);
      rx[0] = 1'b0;
      wait_ticks(320);
      chk("t5_busy_in_break", 32'(busy[0]), 32'd1);
      rx[0] = 1'b1;
      wait_ticks(4);
      chk("t5_busy_after_break", 32'(busy[0]), 32'd0);
      frame(0, 9'h07E, 1'b0, 1'b1);

      // Reset during data bit 3
      wait_ticks(1);
      rx[0] = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 3; i++) begin
         rx[0] = 1'b1;
         wait_ticks(16);
      end
      rx[0] = 1'b1;
      wait_ticks(8);
      chk("t6_busy_midframe", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_outputs_after_reset", {done[0], brk[0], ferr[0], perr[0], busy[0], 19'd0, dout0}, 32'd0);
      rst = 1'b0;
      rx[0] = 1'b1;
      wait_ticks(32);
      frame(0, 9'h0C3, 1'b0, 1'b1);

      // 5 data bits, 2 stop bits
      frame(3, 9'h015, 1'b0, 1'b1);

      // Randomised frames across all configurations
      repeat (30) begin
         idx = $urandom_range(0, 3);
         d = 9'($urandom);
         if ($urandom_range(0, 7) == 0) d = 9'h000;
         pb = 1'b0;
         for (int i = 0; i < cfg_bits(idx); i++) pb = pb ^ d[i];
         if (cfg_par(idx) == 2) pb = ~pb;
         if ($urandom_range(0, 3) == 0) pb = ~pb;
         sv = ($urandom_range(0, 4) != 0);
         frame(idx, d, pb, sv);
      end

      wait_ticks(8);
      chk("u0_no_missing_done", 32'(q0.size()), 32'd0);
      chk("u1_no_missing_done", 32'(q1.size()), 32'd0);
      chk("u2_no_missing_done", 32'(q2.size()), 32'd0);
      chk("u3_no_missing_done", 32'(q3.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
